// File: rtl/chunked_wide_adder_pkg.sv
// Shared types and helpers for the chunked wide adder.
package chunked_wide_adder_pkg;

  typedef enum logic [1:0] {
    CWA_IDLE,
    CWA_RUN,
    CWA_DONE
  } cwa_state_t;

  // Chunk index width; at least one bit so CHUNKS=1 still has a register.
  function automatic int unsigned cwa_idx_width(input int unsigned chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_using_parameter.sv
// N-bit ripple-carry adder: {cout, sum} = a + b + cin.
module ripple_carry_adder_using_parameter #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/chunked_wide_adder.sv
// Multi-cycle W-bit adder, N bits per cycle LSB chunk first, valid/ready in and out.
// Optional two's-complement overflow output enabled by defining CWA_OVERFLOW_EN.
module chunked_wide_adder
  import chunked_wide_adder_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned CHUNKS = 4,
  localparam int unsigned W     = N * CHUNKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
`ifdef CWA_OVERFLOW_EN
  output logic         ovf,
`endif
  output logic         busy
);

  localparam int unsigned IdxW = cwa_idx_width(CHUNKS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CHUNKS - 1);

  cwa_state_t      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [N-1:0]    chunk_a, chunk_b, chunk_sum;
  logic            chunk_cout;

  assign chunk_a = a_q[idx_q*N +: N];
  assign chunk_b = b_q[idx_q*N +: N];

  ripple_carry_adder_using_parameter #(
    .N(N)
  ) u_chunk_adder (
    .a   (chunk_a),
    .b   (chunk_b),
    .cin (carry_q),
    .sum (chunk_sum),
    .cout(chunk_cout)
  );

`ifdef CWA_OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CWA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      CWA_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef CWA_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          state_d = CWA_RUN;
        end
      end
      CWA_RUN: begin
        sum_d[idx_q*N +: N] = chunk_sum;
        carry_d             = chunk_cout;
        if (idx_q == LastIdx) begin
          cout_d  = chunk_cout;
`ifdef CWA_OVERFLOW_EN
          // Top chunk's MSB is sum[W-1].
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (chunk_sum[N-1] != a_q[W-1]);
`endif
          state_d = CWA_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      CWA_DONE: begin
        if (out_ready) state_d = CWA_IDLE;
      end
      default: state_d = CWA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CWA_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CWA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CWA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == CWA_IDLE);
  assign out_valid = (state_q == CWA_DONE);
  assign busy      = (state_q != CWA_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CWA_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_wide_adder.sv
// Directed bench for chunked_wide_adder (CHUNKS=4 and CHUNKS=1 instances).
// Covers ovf as well when CWA_OVERFLOW_EN is defined.
module tb_chunked_wide_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [31:0] a, b, sum;
`ifdef CWA_OVERFLOW_EN
  logic        ovf;
`endif

  logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
  logic [7:0]  a1, b1, sum1;
`ifdef CWA_OVERFLOW_EN
  logic        ovf1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chunked_wide_adder #(.N(8), .CHUNKS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
`ifdef CWA_OVERFLOW_EN
    .ovf      (ovf),
`endif
    .busy     (busy)
  );

  chunked_wide_adder #(.N(8), .CHUNKS(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .a        (a1),
    .b        (b1),
    .cin      (cin1),
    .out_valid(out_valid1),
    .out_ready(out_ready1),
    .sum      (sum1),
    .cout     (cout1),
`ifdef CWA_OVERFLOW_EN
    .ovf      (ovf1),
`endif
    .busy     (busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait for acceptance edge; returns just after E0.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb2, input logic tc);
    int n;
    a = ta; b = tb2; cin = tc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    check("in_ready_before_accept", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
  endtask

  task automatic full_op(input string tag, input logic [31:0] ta, input logic [31:0] tb2,
                         input logic tc, input logic [31:0] esum, input logic ecout);
    int lat;
    start_op(ta, tb2, tc);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready_run"}, in_ready, 0);
    wait_done(lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_cout"}, cout, ecout);
  endtask

  initial begin
    int lat;
    logic seen;
    rst_n = 1'b0; in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
    in_valid1 = 0; out_ready1 = 0; a1 = '0; b1 = '0; cin1 = 0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1: full carry ripple
    full_op("t1", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1);
    handshake();

    // 2: no carries
    full_op("t2", 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0);
    handshake();

    // 3: stall in DONE with input noise
    full_op("t3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = $urandom; b = $urandom; cin = ~cin;
      step();
      check("t3_hold_sum", sum, 32'hFFFF_FFFF);
      check("t3_hold_cout", cout, 1);
      check("t3_hold_out_valid", out_valid, 1);
      check("t3_hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    handshake();
    full_op("t3_next", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    handshake();

    // 4: reset mid-RUN at idx=2
    start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    step(); step();
    rst_n = 1'b0;
    #1;
    check("t4_in_ready", in_ready, 1);
    check("t4_out_valid", out_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_sum", sum, 0);
    check("t4_cout", cout, 0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); seen |= out_valid; end
    check("t4_no_out_valid", seen, 0);
    full_op("t4_next", 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 32'hDFD1_0456, 1'b0);
    handshake();

    // 6: overflow cases (sum/cout checked in every build)
    full_op("t6a", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0);
`ifdef CWA_OVERFLOW_EN
    check("t6a_ovf", ovf, 1);
`endif
    handshake();
    full_op("t6b", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1);
`ifdef CWA_OVERFLOW_EN
    check("t6b_ovf", ovf, 0);
`endif
    handshake();

    // 5: CHUNKS=1 instance
    a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b0; in_valid1 = 1'b1;
    check("t5_in_ready", in_ready1, 1);
    step();
    in_valid1 = 1'b0;
    check("t5_busy", busy1, 1);
    lat = 0;
    while (!out_valid1 && lat < 20) begin step(); lat++; end
    check("t5_latency", lat, 1);
    check("t5_sum", sum1, 8'h00);
    check("t5_cout", cout1, 1);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    check("t5_in_ready_after_hs", in_ready1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
